// File: rtl/ibex_div_responder.sv
// ibex_div_responder: iterative radix-2 restoring divider answering the
// request side of the Ibex multdiv protocol (RV32M DIV/DIVU/REM/REMU).
// The md_op_e encoding is carried here so the block stands on its own.

package ibex_pkg;
    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;
endpackage

// Handshake: the initiator raises div_en_i and holds it together with the
// operands; the unit answers with valid_o and a stable multdiv_result_o.
// A transfer completes on the rising edge where valid_o and
// multdiv_ready_id_i are both high; the unit is back in IDLE the next cycle.
// Dropping div_en_i before that edge aborts the operation, and no result
// is delivered.
module ibex_div_responder (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              div_en_i,
    input  ibex_pkg::md_op_e  operator_i,
    input  logic [1:0]        signed_mode_i,
    input  logic [31:0]       op_a_i,
    input  logic [31:0]       op_b_i,
    input  logic              data_ind_timing_i,
    input  logic              multdiv_ready_id_i,
    output logic [31:0]       multdiv_result_o,
    output logic              valid_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic        is_rem_q;
    logic        a_neg_q;
    logic        b_neg_q;
    logic        special_q;
    logic [31:0] spec_res_q;
    logic [31:0] b_mag_q;
    // Partial remainder. The trial value r' is 33 bits wide, but after each
    // restoring step the remainder is below |b| and always fits in 32 bits.
    logic [31:0] rem_q;
    // Holds |a| at accept; dividend bits shift out the top while quotient
    // bits shift in at the bottom.
    logic [31:0] quo_q;
    logic [31:0] result_q;
    logic        valid_q;

    logic        accept;
    logic        a_neg_d;
    logic        b_neg_d;
    logic [31:0] a_mag_d;
    logic [31:0] b_mag_d;
    logic        div_zero;
    logic        overflow;
    logic        special_d;
    logic [31:0] spec_res_d;
    logic [32:0] r_shift;
    logic        r_ge;
    logic [32:0] r_sub;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_res_d;

    // Accept decode, operand magnitudes, special cases and one restoring step.
    always_comb begin
        accept     = div_en_i && ((operator_i == ibex_pkg::MD_OP_DIV) ||
                                  (operator_i == ibex_pkg::MD_OP_REM));
        a_neg_d    = signed_mode_i[0] & op_a_i[31];
        b_neg_d    = signed_mode_i[1] & op_b_i[31];
        // Two's complement of 0x80000000 is itself, which is the magnitude.
        a_mag_d    = a_neg_d ? (32'd0 - op_a_i) : op_a_i;
        b_mag_d    = b_neg_d ? (32'd0 - op_b_i) : op_b_i;

        div_zero   = (op_b_i == 32'd0);
        overflow   = (signed_mode_i == 2'b11) && (op_a_i == 32'h8000_0000) &&
                     (op_b_i == 32'hFFFF_FFFF);
        special_d  = div_zero || overflow;
        spec_res_d = 32'd0;
        if (div_zero) begin
            spec_res_d = (operator_i == ibex_pkg::MD_OP_REM) ? op_a_i : 32'hFFFF_FFFF;
        end else if (overflow) begin
            spec_res_d = (operator_i == ibex_pkg::MD_OP_REM) ? 32'd0 : 32'h8000_0000;
        end

        r_shift    = {1'b0, rem_q, quo_q[31]};
        r_shift    = {rem_q, quo_q[31]};
        r_ge       = (r_shift >= {1'b0, b_mag_q});
        r_sub      = r_shift - {1'b0, b_mag_q};
        rem_d      = r_ge ? r_sub[31:0] : r_shift[31:0];
        quo_d      = {quo_q[30:0], r_ge};

        quo_fix    = (a_neg_q ^ b_neg_q) ? (32'd0 - quo_q) : quo_q;
        rem_fix    = a_neg_q ? (32'd0 - rem_q) : rem_q;
        if (special_q) begin
            fix_res_d = spec_res_q;
        end else begin
            fix_res_d = is_rem_q ? rem_fix : quo_fix;
        end
    end

    // Control FSM with registered datapath, result and valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            is_rem_q   <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= 32'd0;
            b_mag_q    <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            result_q   <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        is_rem_q   <= (operator_i == ibex_pkg::MD_OP_REM);
                        a_neg_q    <= a_neg_d;
                        b_neg_q    <= b_neg_d;
                        special_q  <= special_d;
                        spec_res_q <= spec_res_d;
                        b_mag_q    <= b_mag_d;
                        quo_q      <= a_mag_d;
                        rem_q      <= 32'd0;
                        cnt_q      <= 5'd0;
                        if (special_d && !data_ind_timing_i) begin
                            result_q <= spec_res_d;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!div_en_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!div_en_i) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= fix_res_d;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (!div_en_i || multdiv_ready_id_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign multdiv_result_o = result_q;
    assign valid_o          = valid_q;
    assign busy_o           = (state_q != IDLE);

endmodule
